// File: rtl/ni_packetizer.sv
// ni_packetizer: NI transmit side of the 4-node ring router.
// Turns a (dest, len) command plus a stream of 6-bit payload words into
// head / body / trailer flits for the router NI input port.
// Optional feature macro: NI_SELF_DROP_EN (drop commands addressed to this node).
module ni_packetizer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] current_node,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dest,
  input  logic [3:0] cmd_len,
  output logic       cmd_ready,
  input  logic       din_valid,
  input  logic [5:0] din,
  output logic       din_ready,
  input  logic       free,
  output logic [7:0] flit_out,
  output logic       busy,
  output logic       err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, WAIT_FREE, HEAD, BODY, TRAIL} state_e;

  state_e          state_q, state_d;
  logic [1:0]      dest_q, dest_d;
  logic [3:0]      rem_q, rem_d;
  logic [7:0]      flit_q, flit_d;
  logic            err_q, err_d;
  logic [5:0]      mem_q [FIFO_DEPTH];
  logic [5:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic cmd_fire, cmd_bad, self_hit, push, pop, fifo_nempty;

`ifdef NI_SELF_DROP_EN
  assign self_hit = (cmd_dest == current_node);
`else
  logic unused_node;
  assign unused_node = ^current_node;
  assign self_hit    = 1'b0;
`endif

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign din_ready   = (count_q != CW'(FIFO_DEPTH));
  assign flit_out    = flit_q;
  assign err         = err_q;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign cmd_bad     = (cmd_len == 4'd0) || (cmd_len > 4'(MAX_LEN)) || self_hit;
  assign push        = din_valid && din_ready;
  assign fifo_nempty = (count_q != '0);

  // State, packet context, output flops and FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      rem_q    <= '0;
      flit_q   <= '0;
      err_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      rem_q    <= rem_d;
      flit_q   <= flit_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cmd_fire && !cmd_bad) state_d = WAIT_FREE;
      WAIT_FREE: if (free) state_d = HEAD;
      HEAD:      state_d = BODY;
      BODY:      if (rem_q == '0) state_d = TRAIL;
      TRAIL:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Flit for the next cycle, pop request, command latch and error pulse.
  // flit_q is registered, so each state prepares the flit shown in the
  // following cycle: WAIT_FREE loads the head, HEAD/BODY load bodies, and
  // BODY with nothing left loads the trailer (shown while in TRAIL).
  always_comb begin
    flit_d = 8'h00;
    err_d  = 1'b0;
    pop    = 1'b0;
    dest_d = dest_q;
    rem_d  = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            dest_d = cmd_dest;
            rem_d  = cmd_len;
          end
        end
      end
      WAIT_FREE: if (free) flit_d = {6'b101111, dest_q};
      HEAD: begin
        if (fifo_nempty) begin
          pop    = 1'b1;
          flit_d = {2'b01, mem_q[rd_ptr_q]};
          rem_d  = rem_q - 4'd1;
        end
      end
      BODY: begin
        if (rem_q == '0) begin
          flit_d = 8'hFF;
        end else if (fifo_nempty) begin
          pop    = 1'b1;
          flit_d = {2'b01, mem_q[rd_ptr_q]};
          rem_d  = rem_q - 4'd1;
        end
      end
      default: flit_d = 8'h00;
    endcase
  end

  // Payload FIFO bookkeeping; full/empty come from the registered count,
  // so a same-cycle pop never unblocks a push and a new word pops next cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface transmit block for the 4-node ring router. It accepts a packet command (destination, length) and a stream of 6-bit payload words from the local core, and emits 8-bit flits into the router's NI input port: a head flit, then body flits, then a trailer, each on its own cycle. It injects a new head only while the router's switch controller signals `free`. It is the injecting end of the flit protocol that the switch controller consumes.

## Interface
- `FIFO_DEPTH`, 4: payload FIFO entries; power of two, 2..16.
- `MAX_LEN`, 8: maximum body flits per packet; 1..15.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `current_node` input 2: this node's address.
- `cmd_valid` input 1: packet command present.
- `cmd_dest` input 2: destination node.
- `cmd_len` input 4: body flit count, 1..MAX_LEN.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `din_valid` input 1: payload word present.
- `din` input 6: payload word.
- `din_ready` output 1: FIFO not full; word pushed when `din_valid && din_ready`.
- `free` input 1: router switch is not holding a packet.
- `flit_out` output 8: flit to router NI input; 8'h00 = idle.
- `busy` output 1: packet in progress (state != IDLE).
- `err` output 1: one-cycle pulse on an illegal or dropped command.

## Operation
- Flit encodings: head = {6'b101111, dest[1:0]} (8'hBC..8'hBF); body = {2'b01, din[5:0]} (8'h40..8'h7F); trailer = 8'hFF; idle = 8'h00. A body flit can never alias idle, head or trailer.
- FSM states:
  - **IDLE**: `cmd_ready=1`. On an accepted command, latch `cmd_dest` and `cmd_len`, then go to WAIT_FREE.
  - **WAIT_FREE**: emit idle. When `free=1`, go to HEAD.
  - **HEAD**: emit the head flit for one cycle, then go to BODY.
  - **BODY**: when the FIFO is non-empty, pop one word, emit the body flit, and decrement the remaining count. When the FIFO is empty, emit idle (bubble) and hold state. After the last body flit, go to TRAIL.
  - **TRAIL**: emit 8'hFF for one cycle, then go to IDLE.
- `free` is sampled only in WAIT_FREE. Once the head is sent, the packet completes regardless of `free`.
- An accepted command with `cmd_len==0` or `cmd_len>MAX_LEN` is not latched: pulse `err`, stay in IDLE.
- The FIFO accepts writes in every state, including IDLE before a command arrives.
- FIFO full: `din_ready=0`. A pop in the same cycle does not unblock the push; the push succeeds the next cycle.
- FIFO empty: a word pushed in cycle T is poppable at T+1 at the earliest.
- Reset (asynchronous, any time, including mid-packet): state=IDLE; FIFO pointers and count cleared (contents discarded); `flit_out=8'h00`, `cmd_ready=1` after release, `din_ready=1`, `busy=0`, `err=0`. A truncated packet has no trailer; system-level recovery is outside this block.

## Timing
- All outputs are registered, except `cmd_ready`, `din_ready` and `busy`, which decode directly from registered state and count.
- Command accepted at edge T → WAIT_FREE at T+1.
- `free=1` sampled in WAIT_FREE at cycle C → head on `flit_out` at C+1.
- With a pre-filled FIFO, an N-body packet occupies head + N + trailer = N+2 consecutive cycles, and the next command is accepted in the cycle after the trailer.
- Minimum command-to-head latency is 2 cycles.
- `err` is high for exactly one cycle, the cycle after the offending command.

## Configuration
- `NI_SELF_DROP_EN`:
  - **Defined**: a command with `cmd_dest==current_node` is consumed (handshake completes), no flits are emitted, `err` pulses, and the FIFO is untouched.
  - **Undefined**: the command is sent normally, and the router delivers it straight back to the local NI.

## Test plan
- Reset mid-BODY: assert `rst_n=0` → `flit_out=8'h00`, `busy=0`, `din_ready=1` immediately; after release, a new command produces a correct packet.
- Pre-fill 3 words (0x01, 0x2A, 0x3F), command dest=2, len=3, `free=1` → `flit_out` sequence 0xBE, 0x41, 0x6A, 0x7F, 0xFF on consecutive cycles, then 0x00.
- Command dest=1 with `free=0` for 5 cycles then 1 → idle held for 5 cycles, head 0xBD one cycle after `free` rises, `busy` high throughout.
- len=4 with the FIFO fed one word every 3 cycles → 0x00 bubbles between body flits, exactly 4 body flits, one trailer, no second head.
- `cmd_len=0`, then `cmd_len=9` (MAX_LEN=8) → `err` pulses once each, no flits emitted, FSM stays in IDLE; fill the FIFO to 4 → `din_ready=0` until the first pop.
- With `NI_SELF_DROP_EN` defined and `current_node=3`: command dest=3 → `err` pulse, `flit_out` stays 0x00. Without it → head 0xBF is emitted.
